// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package regfile_sched_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int RF_DATA_W  = 32;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0]  data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the WB, long-latency dispatch/result, decode-source and
// register-file write-port signals around the scheduler.
// slave  = the scheduler itself, master = the surrounding pipeline.
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 32
);
    import regfile_sched_pkg::*;

    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;

    logic                  ll_issue_valid;
    logic [REG_ADDR_W-1:0] ll_issue_addr;
    logic                  ll_issue_ready;

    logic                  ll_res_valid;
    logic [REG_ADDR_W-1:0] ll_res_addr;
    logic [DATA_W-1:0]     ll_res_data;
    logic                  ll_res_ready;

    logic [REG_ADDR_W-1:0] src1_addr;
    logic [REG_ADDR_W-1:0] src2_addr;
    logic                  hazard_stall;
    logic [NUM_REGS-1:0]   busy_vec;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_a3;
    logic [DATA_W-1:0]     rf_wd3;

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  ll_issue_valid, ll_issue_addr,
        output ll_issue_ready,
        input  ll_res_valid, ll_res_addr, ll_res_data,
        output ll_res_ready,
        input  src1_addr, src2_addr,
        output hazard_stall, busy_vec,
        output rf_we, rf_a3, rf_wd3
    );

    modport master (
        output wb_we, wb_addr, wb_data,
        output ll_issue_valid, ll_issue_addr,
        input  ll_issue_ready,
        output ll_res_valid, ll_res_addr, ll_res_data,
        input  ll_res_ready,
        output src1_addr, src2_addr,
        input  hazard_stall, busy_vec,
        input  rf_we, rf_a3, rf_wd3
    );

endinterface

// File: rtl/regfile_wb_scheduler_fifo.sv
// Small synchronous FIFO holding long-latency results until the register
// file write port is free. Caller guarantees no push when full and no pop
// when empty.
module rf_wr_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = regfile_sched_pkg::rf_wr_t
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     rd_data,
    output logic full,
    output logic empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    // Storage needs no reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: WB has strict priority, buffered
// long-latency results fill idle slots. A scoreboard of registers awaiting
// long-latency results drives the decode-stage hazard stall and blocks
// write-after-write dispatches.
// Optional feature macro: REGFILE_WB_SCHED_BYPASS_EN -- when defined, a
// result arriving while the buffer is empty and WB leaves the port idle is
// written in its acceptance cycle instead of being buffered.
module regfile_wb_scheduler #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input logic                   clk,
    input logic                   rstn,
    regfile_wb_scheduler_if.slave bus
);
    import regfile_sched_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_t;

    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic [CNT_W-1:0]      inflight;

    wr_t                   fifo_wr;
    wr_t                   fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;

    logic                  wb_take;
    logic                  head_pop;
    logic                  bypass;
    logic                  res_accept;
    logic                  issue_accept;
    logic                  retire;
    logic [REG_ADDR_W-1:0] clr_addr;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_a3;
    logic [DATA_W-1:0]     rf_wd3;

    assign wb_take  = bus.wb_we && (bus.wb_addr != '0);
    assign head_pop = !wb_take && !fifo_empty;

`ifdef REGFILE_WB_SCHED_BYPASS_EN
    // rstn gating keeps the port WB-only while reset is asserted.
    assign bypass = rstn && !wb_take && fifo_empty && bus.ll_res_valid;
`else
    assign bypass = 1'b0;
`endif

    assign bus.ll_issue_ready = (inflight < CNT_W'(DEPTH)) && !busy[bus.ll_issue_addr];
    assign bus.ll_res_ready   = !fifo_full;
    assign bus.hazard_stall   = ((bus.src1_addr != '0) && busy[bus.src1_addr]) ||
                                ((bus.src2_addr != '0) && busy[bus.src2_addr]);
    assign bus.busy_vec       = busy;

    assign issue_accept = bus.ll_issue_valid && bus.ll_issue_ready;
    assign res_accept   = bus.ll_res_valid && bus.ll_res_ready;
    assign fifo_push    = res_accept && !bypass;
    assign retire       = head_pop || bypass;
    assign clr_addr     = head_pop ? fifo_head.addr : bus.ll_res_addr;

    assign fifo_wr.addr = bus.ll_res_addr;
    assign fifo_wr.data = bus.ll_res_data;

    rf_wr_fifo #(
        .DEPTH (DEPTH),
        .T     (wr_t)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (head_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Write-port mux: WB first, then buffer head, then (optionally) bypass.
    always_comb begin
        rf_we  = 1'b0;
        rf_a3  = '0;
        rf_wd3 = '0;
        if (wb_take) begin
            rf_we  = 1'b1;
            rf_a3  = bus.wb_addr;
            rf_wd3 = bus.wb_data;
        end else if (head_pop) begin
            rf_we  = (fifo_head.addr != '0);
            rf_a3  = fifo_head.addr;
            rf_wd3 = fifo_head.data;
        end else if (bypass) begin
            rf_we  = (bus.ll_res_addr != '0);
            rf_a3  = bus.ll_res_addr;
            rf_wd3 = bus.ll_res_data;
        end
    end

    assign bus.rf_we  = rf_we;
    assign bus.rf_a3  = rf_a3;
    assign bus.rf_wd3 = rf_wd3;

    // Scoreboard update: clear on result write, set on accepted dispatch.
    // The two never target the same register because dispatch requires !busy.
    always_comb begin
        busy_nxt = busy;
        if (retire) busy_nxt[clr_addr] = 1'b0;
        if (issue_accept && (bus.ll_issue_addr != '0)) busy_nxt[bus.ll_issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard and in-flight count registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy     <= '0;
            inflight <= '0;
        end else begin
            busy <= busy_nxt;
            case ({issue_accept, retire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifndef SYNTHESIS
    wb_writes_busy_reg_a: assert property (@(posedge clk) disable iff (!rstn)
        !(bus.wb_we && (bus.wb_addr != '0) && busy[bus.wb_addr]));
`endif

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Schedules the register file's single write port (a3/we3/wd3) between the in-order pipeline writeback stage and a long-latency execution unit (multiply/divide). Also keeps a scoreboard of registers awaiting long-latency results and raises an issue stall on read-after-write and write-after-write hazards. Sits between the WB stage, the long-latency unit and the register file. Feeds the hazard unit.

## Interface
- `DEPTH`, 2: maximum long-latency ops in flight, which is also the pending-result buffer depth (≥1).
- `DATA_W`, 32: write data width.

- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `wb_we` in 1, `wb_addr` in 5, `wb_data` in DATA_W: pipeline writeback request. Never stalled.
- `ll_issue_valid` in 1, `ll_issue_addr` in 5: a long-latency op is dispatched with this destination.
- `ll_issue_ready` out 1: dispatch accepted when high together with `ll_issue_valid`.
- `ll_res_valid` in 1, `ll_res_addr` in 5, `ll_res_data` in DATA_W: a long-latency result is offered.
- `ll_res_ready` out 1: result accepted when high together with `ll_res_valid`.
- `src1_addr` in 5, `src2_addr` in 5: source registers of the decode-stage instruction.
- `hazard_stall` out 1: the decode-stage instruction must stall.
- `busy_vec` out 32: scoreboard bits.
- `rf_we` out 1, `rf_a3` out 5, `rf_wd3` out DATA_W: drive the register file write port.

## Operation
- Scoreboard: `busy[r]` is set when a dispatch to `r != 0` is accepted. It is cleared in the cycle the result for `r` is written to the register file. `busy[0]` is always 0.
- Dispatch: `ll_issue_ready = (inflight < DEPTH) && !busy[ll_issue_addr]`. This refuses write-after-write dispatches to a register that is already busy.
- Dispatch to r0 is accepted and counted in `inflight`. Its result is popped without asserting `rf_we`.
- `inflight` counter: +1 on an accepted dispatch, −1 when a buffered result is retired. Simultaneous +1 and −1 leave it unchanged. Range 0..DEPTH.
- Result buffer: a FIFO of {addr, data}. `ll_res_ready = !full`. Because of the `inflight` limit the buffer cannot overflow.
- Port arbitration, WB has strict priority:
  - if `wb_we && wb_addr != 0`, the port carries the WB request;
  - else if the buffer is non-empty, the buffer head is popped onto the port (`rf_we = head.addr != 0`);
  - else `rf_we = 0`.
- WB writes to r0 are dropped and do not take the port.
- `hazard_stall = (src1_addr != 0 && busy[src1_addr]) || (src2_addr != 0 && busy[src2_addr])`. WB-to-decode forwarding is handled by the register file; this block does not stall for it.
- The WB stage writing a busy register is a protocol violation. A simulation assertion flags it.
- Buffered results can starve while WB writes every cycle. This is accepted, and there is no aging.

## Timing
- `hazard_stall`, `ll_issue_ready`, `ll_res_ready` and the `rf_*` outputs are combinational from inputs and registered state. `busy_vec`, `inflight` and the buffer are registered.
- Without bypass, an accepted result reaches `rf_we` at the earliest 1 cycle after acceptance. The busy bit clears at the edge ending that write cycle.
- A stalled reader of register r sees `hazard_stall = 0` in the cycle after the write. It reads the new value from the register file.
- Reset (asynchronous, may occur mid-operation):
  - `busy_vec = 0`, `inflight = 0`, buffer empty;
  - in-flight results are discarded, so the long-latency unit must share `rstn`;
  - during reset, `rf_we` follows WB only, `ll_res_ready = 1`, `hazard_stall = 0`, `ll_issue_ready = 1`.

## Configuration
- `REGFILE_WB_SCHED_BYPASS_EN` defined: if the buffer is empty and WB does not take the port, an accepted result is written in its acceptance cycle. Latency is 0, and its busy bit clears at that edge. Otherwise it is enqueued as normal.
- Not defined: every result passes through the buffer, with minimum latency 1.

## Structure
- Package `regfile_sched_pkg` holds:
  - `REG_ADDR_W = 5`, `NUM_REGS = 32`;
  - `typedef struct packed {logic [4:0] addr; logic [DATA_W-1:0] data;} rf_wr_t`.
- One sub-module, `rf_wr_fifo`: a synchronous FIFO of `rf_wr_t`, depth DEPTH, with `full`, `empty`, `push`, `pop` and async active-low reset.

## Test plan
- Dispatch r5; `src1_addr = 5`: `hazard_stall = 1` until the result write. The result for r5 (0xDEADBEEF) reaches `rf_we/rf_a3 = 5/rf_wd3 = 0xDEADBEEF` 1 cycle after acceptance. The stall drops the next cycle.
- WB writes r3 every cycle while a result for r7 is buffered: only r3 writes occur. When WB goes idle, r7 is written the same cycle.
- Dispatch r5 while r5 is busy: `ll_issue_ready = 0`. DEPTH = 2, two ops in flight, dispatch r9: `ll_issue_ready = 0` until a retirement.
- Dispatch to r0, then its result arrives: `rf_we` stays 0, `inflight` returns to 0, `busy_vec` stays 0.
- Assert `rstn` low with two results buffered and r4/r6 busy: all state clears immediately and no buffered write appears after release.
- With `REGFILE_WB_SCHED_BYPASS_EN` and the port idle: a result for r2 (0x1234) drives `rf_we = 1, rf_a3 = 2` in its acceptance cycle.
